// File: rtl/mdu_pkg.sv
// Shared op codes, state encoding and counter sizing for the multiply/divide unit.
package mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MDOP_NONE  = 3'd0,
        MDOP_MULT  = 3'd1,
        MDOP_MULTU = 3'd2,
        MDOP_DIV   = 3'd3,
        MDOP_DIVU  = 3'd4,
        MDOP_MTHI  = 3'd5,
        MDOP_MTLO  = 3'd6
    } mdop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result.
// The divider exists only when MDU_DIV_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] a_zx;
    logic [63:0] b_zx;
    logic [63:0] smul;
    logic [63:0] umul;

    // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
    assign a_sx = {{32{a[31]}}, a};
    assign b_sx = {{32{b[31]}}, b};
    assign a_zx = {32'd0, a};
    assign b_zx = {32'd0, b};
    assign smul = a_sx * b_sx;
    assign umul = a_zx * b_zx;

`ifdef MDU_DIV_EN
    logic        b_zero;
    logic [31:0] b_safe;
    logic [31:0] squot;
    logic [31:0] srem;
    logic [31:0] uquot;
    logic [31:0] urem;

    // A zero divisor is replaced by 1 so the divider never produces X; its result is discarded.
    assign b_zero = (b == 32'd0);
    assign b_safe = b_zero ? 32'd1 : b;
    assign squot  = $signed(a) / $signed(b_safe);
    assign srem   = $signed(a) % $signed(b_safe);
    assign uquot  = a / b_safe;
    assign urem   = a % b_safe;
`endif

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (op)
            MDOP_MULT:  result = smul;
            MDOP_MULTU: result = umul;
`ifdef MDU_DIV_EN
            MDOP_DIV: begin
                div_zero = b_zero;
                result   = {srem, squot};
            end
            MDOP_DIVU: begin
                div_zero = b_zero;
                result   = {urem, uquot};
            end
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency countdown, HI/LO ownership and
// the D-stage stall request. Divide support is enabled by defining MDU_DIV_EN.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  md_op_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      res_q, res_d;
    logic             dz_q, dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      arith_res;
    logic             arith_dz;
    logic             start_e;

    mdu_arith u_arith (
        .op       (md_op_e),
        .a        (rs_e),
        .b        (rt_e),
        .result   (arith_res),
        .div_zero (arith_dz)
    );

`ifdef MDU_DIV_EN
    assign start_e = (md_op_e == MDOP_MULT) || (md_op_e == MDOP_MULTU) ||
                     (md_op_e == MDOP_DIV)  || (md_op_e == MDOP_DIVU);
`else
    assign start_e = (md_op_e == MDOP_MULT) || (md_op_e == MDOP_MULTU);
`endif

    assign busy     = (state_q == ST_BUSY);
    assign md_stall = md_use_d & (busy | start_e);
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_e) begin
                    res_d   = arith_res;
                    dz_d    = arith_dz;
                    cnt_d   = is_div_op(md_op_e) ? DIV_CNT : MULT_CNT;
                    state_d = ST_BUSY;
                end else if (md_op_e == MDOP_MTHI) begin
                    hi_d = rs_e;
                end else if (md_op_e == MDOP_MTLO) begin
                    lo_d = rs_e;
                end
            end
            ST_BUSY: begin
                // Ops arriving here are dropped; the hazard logic should have held them in D.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (!dz_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with hand-computed HI/LO, busy and stall expectations.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  md_op_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    int n_vec;
    int n_err;

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_op_e  (md_op_e),
        .rs_e     (rs_e),
        .rt_e     (rt_e),
        .md_use_d (md_use_d),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one op at the current negedge, check the start-cycle stall, then return to NONE.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall);
        md_op_e = op;
        rs_e    = a;
        rt_e    = b;
        #1;
        chk("start_stall", {31'd0, md_stall}, {31'd0, exp_stall});
        next_cycle();
        md_op_e = MDOP_NONE;
        rs_e    = '0;
        rt_e    = '0;
    endtask

    task automatic run_busy(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_stall"}, {31'd0, md_stall}, {31'd0, md_use_d});
            next_cycle();
        end
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        md_op_e  = MDOP_NONE;
        rs_e     = '0;
        rt_e     = '0;
        md_use_d = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // MULT -3 * 7 with a dependent instruction waiting in D.
        md_use_d = 1'b1;
        issue(MDOP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        run_busy(5, "mult");
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        chk("mult_stall_clear", {31'd0, md_stall}, 32'd0);

        // MULTU max*max; an MTLO and a MULT arriving while busy must both be dropped.
        issue(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        md_op_e = MDOP_MTLO;
        rs_e    = 32'h0000_1234;
        #1;
        chk("busy_mtlo_stall", {31'd0, md_stall}, 32'd1);
        next_cycle();
        md_op_e = MDOP_MULT;
        rs_e    = 32'd9;
        rt_e    = 32'd9;
        next_cycle();
        md_op_e = MDOP_NONE;
        rs_e    = '0;
        rt_e    = '0;
        chk("busy_mtlo_dropped", lo, 32'hFFFF_FFEB);
        run_busy(3, "multu");
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // New start in the very cycle busy falls.
        issue(MDOP_MULT, 32'd2, 32'd3, 1'b1);
        run_busy(5, "b2b");
        chk("b2b_hi", hi, 32'h0);
        chk("b2b_lo", lo, 32'h6);

        // MTLO/MTHI while idle: one-edge latency, no busy, no stall.
        issue(MDOP_MTLO, 32'h0000_1234, 32'd0, 1'b0);
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        issue(MDOP_MTHI, 32'h0000_CAFE, 32'd0, 1'b0);
        chk("mthi_hi", hi, 32'h0000_CAFE);
        chk("mthi_lo_kept", lo, 32'h0000_1234);
        chk("mthi_busy", {31'd0, busy}, 32'd0);

`ifdef MDU_DIV_EN
        issue(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_busy(10, "div");
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue(MDOP_DIVU, 32'd7, 32'd0, 1'b1);
        run_busy(10, "divz");
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);
        issue(MDOP_DIVU, 32'd7, 32'd2, 1'b1);
        run_busy(10, "divu");
        chk("divu_lo", lo, 32'h3);
        chk("divu_hi", hi, 32'h1);
        issue(MDOP_DIV, 32'd25, 32'd5, 1'b1);
`else
        issue(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("nodiv_busy", {31'd0, busy}, 32'd0);
        chk("nodiv_hi", hi, 32'h0000_CAFE);
        chk("nodiv_lo", lo, 32'h0000_1234);
        issue(MDOP_DIVU, 32'd7, 32'd0, 1'b0);
        chk("nodivu_busy", {31'd0, busy}, 32'd0);
        chk("nodivu_lo", lo, 32'h0000_1234);
        issue(MDOP_MULT, 32'd25, 32'd5, 1'b1);
`endif
        // Reset mid-operation: abort with no commit afterwards.
        next_cycle();
        next_cycle();
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) next_cycle();
        chk("post_abort_busy", {31'd0, busy}, 32'd0);
        chk("post_abort_hi", hi, 32'h0);
        chk("post_abort_lo", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
